// File: rtl/msrv32_pipe_stage_reg.sv
// msrv32_pipe_stage_reg
//   Reusable pipeline stage register with a valid/ready handshake, a one-entry
//   skid buffer, flush, and a saturating downstream-stall counter. It carries
//   an opaque payload plus the integer-adder result. Bit 0 of the adder result
//   is cleared when the beat is accepted with branch_taken_in set.
//
// Ports
//   clk_in, reset_in            clock, synchronous active-high reset
//   flush_in                    drop all held beats and the beat offered now
//   up_valid_in / up_ready_out  upstream handshake
//   payload_in, iadder_in       upstream beat contents
//   branch_taken_in             forces bit 0 of the captured iadder to 0
//   dn_valid_out / dn_ready_in  downstream handshake
//   payload_out, iadder_out     beat held in the main register
//   occupancy_out               number of beats held (0..2)
//   stall_count_out             saturating count of dn_valid && !dn_ready cycles
module msrv32_pipe_stage_reg #(
  parameter int WIDTH     = 32,
  parameter int PAYLOAD_W = 160,
  parameter int CNT_W     = 16
) (
  input  logic                 clk_in,
  input  logic                 reset_in,
  input  logic                 flush_in,
  input  logic                 up_valid_in,
  output logic                 up_ready_out,
  input  logic [PAYLOAD_W-1:0] payload_in,
  input  logic [WIDTH-1:0]     iadder_in,
  input  logic                 branch_taken_in,
  output logic                 dn_valid_out,
  input  logic                 dn_ready_in,
  output logic [PAYLOAD_W-1:0] payload_out,
  output logic [WIDTH-1:0]     iadder_out,
  output logic [1:0]           occupancy_out,
  output logic [CNT_W-1:0]     stall_count_out
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [PAYLOAD_W-1:0] r_main_payload;
  logic [WIDTH-1:0]     r_main_iadder;
  logic [PAYLOAD_W-1:0] r_skid_payload;
  logic [WIDTH-1:0]     r_skid_iadder;
  logic [CNT_W-1:0]     r_stall_cnt;

  logic                 w_dn_valid;
  logic                 w_up_ready;
  logic [1:0]           w_occupancy;
  logic                 w_accept;
  logic                 w_take;
  logic                 w_load_main_in;
  logic                 w_load_skid_in;
  logic                 w_load_main_skid;
  logic [WIDTH-1:0]     w_iadder_cap;

  assign w_accept     = up_valid_in && w_up_ready;
  assign w_take       = w_dn_valid && dn_ready_in;
  assign w_iadder_cap = {iadder_in[WIDTH-1:1], iadder_in[0] & ~branch_taken_in};

  // State register
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; flush overrides every handshake
  always_comb begin
    w_next_state = r_state;
    if (flush_in) begin
      w_next_state = S_EMPTY;
    end else begin
      unique case (r_state)
        S_EMPTY: if (w_accept) w_next_state = S_ONE;
        S_ONE: begin
          if (w_accept && !w_take)      w_next_state = S_FULL;
          else if (!w_accept && w_take) w_next_state = S_EMPTY;
        end
        S_FULL:  if (w_take) w_next_state = S_ONE;
        default: w_next_state = S_EMPTY;
      endcase
    end
  end

  // Outputs decoded purely from the state register, so no input reaches them
  always_comb begin
    w_dn_valid  = 1'b0;
    w_up_ready  = 1'b1;
    w_occupancy = 2'd0;
    unique case (r_state)
      S_EMPTY: begin w_dn_valid = 1'b0; w_up_ready = 1'b1; w_occupancy = 2'd0; end
      S_ONE:   begin w_dn_valid = 1'b1; w_up_ready = 1'b1; w_occupancy = 2'd1; end
      S_FULL:  begin w_dn_valid = 1'b1; w_up_ready = 1'b0; w_occupancy = 2'd2; end
      default: begin w_dn_valid = 1'b0; w_up_ready = 1'b1; w_occupancy = 2'd0; end
    endcase
  end

  // Data-path load enables; a flush leaves the data registers untouched
  assign w_load_main_in   = !flush_in && w_accept &&
                            ((r_state == S_EMPTY) || ((r_state == S_ONE) && w_take));
  assign w_load_skid_in   = !flush_in && w_accept && (r_state == S_ONE) && !w_take;
  assign w_load_main_skid = !flush_in && (r_state == S_FULL) && w_take;

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_main_payload <= '0;
      r_main_iadder  <= '0;
      r_skid_payload <= '0;
      r_skid_iadder  <= '0;
    end else begin
      if (w_load_main_in) begin
        r_main_payload <= payload_in;
        r_main_iadder  <= w_iadder_cap;
      end else if (w_load_main_skid) begin
        r_main_payload <= r_skid_payload;
        r_main_iadder  <= r_skid_iadder;
      end
      if (w_load_skid_in) begin
        r_skid_payload <= payload_in;
        r_skid_iadder  <= w_iadder_cap;
      end
    end
  end

  // Stall counter survives flush; only reset clears it
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_stall_cnt <= '0;
    end else if (w_dn_valid && !dn_ready_in && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign up_ready_out    = w_up_ready;
  assign dn_valid_out    = w_dn_valid;
  assign occupancy_out   = w_occupancy;
  assign payload_out     = r_main_payload;
  assign iadder_out      = r_main_iadder;
  assign stall_count_out = r_stall_cnt;

endmodule

// File: tb/tb_msrv32_pipe_stage_reg.sv
// Directed bench for msrv32_pipe_stage_reg: reset, streaming, skid ordering,
// branch LSB clearing, flush, and stall-counter saturation (CNT_W = 4).
module tb_msrv32_pipe_stage_reg;

  localparam int WIDTH     = 32;
  localparam int PAYLOAD_W = 160;
  localparam int CNT_W     = 4;

  logic                 clk;
  logic                 reset;
  logic                 flush;
  logic                 up_valid;
  logic                 up_ready;
  logic [PAYLOAD_W-1:0] payload_in;
  logic [WIDTH-1:0]     iadder_in;
  logic                 branch_taken;
  logic                 dn_valid;
  logic                 dn_ready;
  logic [PAYLOAD_W-1:0] payload_out;
  logic [WIDTH-1:0]     iadder_out;
  logic [1:0]           occupancy;
  logic [CNT_W-1:0]     stall_count;

  int n_tests = 0;
  int n_fail  = 0;

  msrv32_pipe_stage_reg #(
    .WIDTH    (WIDTH),
    .PAYLOAD_W(PAYLOAD_W),
    .CNT_W    (CNT_W)
  ) dut (
    .clk_in         (clk),
    .reset_in       (reset),
    .flush_in       (flush),
    .up_valid_in    (up_valid),
    .up_ready_out   (up_ready),
    .payload_in     (payload_in),
    .iadder_in      (iadder_in),
    .branch_taken_in(branch_taken),
    .dn_valid_out   (dn_valid),
    .dn_ready_in    (dn_ready),
    .payload_out    (payload_out),
    .iadder_out     (iadder_out),
    .occupancy_out  (occupancy),
    .stall_count_out(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle before sampling
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] val, input logic br);
    up_valid     = 1'b1;
    iadder_in    = val;
    payload_in   = {5{val}};
    branch_taken = br;
  endtask

  initial begin
    reset        = 1'b1;
    flush        = 1'b0;
    up_valid     = 1'b1;
    payload_in   = '1;
    iadder_in    = '1;
    branch_taken = 1'b0;
    dn_ready     = 1'b0;

    // Reset held two cycles with an offered beat
    step();
    step();
    check("rst_dn_valid", 160'(dn_valid), 160'(0));
    check("rst_up_ready", 160'(up_ready), 160'(1));
    check("rst_occ",      160'(occupancy), 160'(0));
    check("rst_iadder",   160'(iadder_out), 160'(0));
    check("rst_payload",  160'(payload_out), 160'(0));
    check("rst_stall",    160'(stall_count), 160'(0));

    // Streaming
    reset    = 1'b0;
    dn_ready = 1'b1;
    offer(32'h100, 1'b0);
    step();
    check("str0_valid",  160'(dn_valid), 160'(1));
    check("str0_iadder", 160'(iadder_out), 160'(32'h100));
    check("str0_occ",    160'(occupancy), 160'(1));
    offer(32'h104, 1'b0);
    step();
    check("str1_iadder",  160'(iadder_out), 160'(32'h104));
    check("str1_payload", 160'(payload_out), {5{32'h104}});
    check("str1_occ",     160'(occupancy), 160'(1));
    offer(32'h108, 1'b0);
    step();
    check("str2_iadder", 160'(iadder_out), 160'(32'h108));
    check("str2_occ",    160'(occupancy), 160'(1));
    up_valid = 1'b0;
    step();
    check("str_drain_valid", 160'(dn_valid), 160'(0));
    check("str_drain_occ",   160'(occupancy), 160'(0));
    check("str_stall",       160'(stall_count), 160'(0));

    // Skid: A accepted, B accepted while downstream stalls
    offer(32'h10, 1'b0);
    step();
    dn_ready = 1'b0;
    offer(32'h20, 1'b0);
    step();
    check("skid_occ",      160'(occupancy), 160'(2));
    check("skid_up_ready", 160'(up_ready), 160'(0));
    check("skid_dn_A",     160'(iadder_out), 160'(32'h10));
    offer(32'h40, 1'b0);   // must be refused while FULL
    step();
    check("skid_hold_A",   160'(iadder_out), 160'(32'h10));
    check("skid_hold_occ", 160'(occupancy), 160'(2));
    up_valid = 1'b0;
    dn_ready = 1'b1;
    step();
    check("skid_out_B",     160'(iadder_out), 160'(32'h20));
    check("skid_out_B_occ", 160'(occupancy), 160'(1));
    step();
    check("skid_empty",  160'(dn_valid), 160'(0));
    check("skid_stalls", 160'(stall_count), 160'(2));

    // Branch LSB
    offer(32'h0000_1003, 1'b1);
    step();
    check("br_taken", 160'(iadder_out), 160'(32'h0000_1002));
    check("br_taken_payload", 160'(payload_out), {5{32'h0000_1003}});
    offer(32'h0000_1003, 1'b0);
    step();
    check("br_not_taken", 160'(iadder_out), 160'(32'h0000_1003));
    up_valid = 1'b0;
    step();
    check("br_empty", 160'(dn_valid), 160'(0));

    // Flush from FULL while C is offered
    dn_ready = 1'b0;
    offer(32'h50, 1'b0);
    step();
    offer(32'h60, 1'b0);
    step();
    check("fl_full_occ", 160'(occupancy), 160'(2));
    flush = 1'b1;
    offer(32'h30, 1'b0);
    step();
    check("fl_dn_valid", 160'(dn_valid), 160'(0));
    check("fl_occ",      160'(occupancy), 160'(0));
    check("fl_up_ready", 160'(up_ready), 160'(1));
    check("fl_stale",    160'(iadder_out), 160'(32'h50));
    flush    = 1'b0;
    up_valid = 1'b0;
    dn_ready = 1'b1;
    step();
    check("fl_no_C", 160'(dn_valid), 160'(0));
    check("fl_stall_kept", 160'(stall_count), 160'(4));

    // Saturation: 4 + 20 stalled cycles clamps at 0xF
    dn_ready = 1'b0;
    offer(32'h70, 1'b0);
    step();
    up_valid = 1'b0;
    for (int i = 0; i < 20; i++) step();
    check("sat_count",  160'(stall_count), 160'(4'hF));
    check("sat_held",   160'(iadder_out), 160'(32'h70));
    check("sat_valid",  160'(dn_valid), 160'(1));

    // Reset together with flush drops the held beat and clears the counter
    reset = 1'b1;
    flush = 1'b1;
    step();
    check("rst2_valid",  160'(dn_valid), 160'(0));
    check("rst2_stall",  160'(stall_count), 160'(0));
    check("rst2_iadder", 160'(iadder_out), 160'(0));
    check("rst2_ready",  160'(up_ready), 160'(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
